mem_channel_arbiter: RTL

- Shares NUM_CHANNELS data-memory channels among NUM_CONSUMERS load/store requesters (the per-thread LSUs of a core, or cores at the gpu level).
- Sits between the LSUs and the external data memory interface. Uses the same valid/ready read/write handshake on both sides.
- Round-robin fair grant. One outstanding transaction per channel. Each consumer is served by at most one channel at a time.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_channel.sv | 122 ++++++++++++
 rtl/mem_channel_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory channel arbiter.
//   channel_state_e : per-channel transaction state
//   idx_width()     : bit width of a consumer index ($clog2, minimum 1)
package mem_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReadWait,
        StWriteWait,
        StReadRelay,
        StWriteRelay
    } channel_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_channel.sv
// One memory channel: carries a single transaction from grant through the memory
// handshake to the relay back to the owning consumer.
// Inputs : clk, reset_n (async, active-low), grant_* (request chosen by the top),
//          owner_read_valid/owner_write_valid (valids of the latched owner),
//          mem_read_ready/mem_read_data/mem_write_ready (memory side).
// Outputs: busy, release_claim, owner_idx, registered mem_* request signals and
//          registered consumer-side ready/data for the owner.
module mem_arb_channel
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned IDX_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 grant_valid,
    input  logic [IDX_BITS-1:0]  grant_idx,
    input  logic                 grant_is_write,
    input  logic [ADDR_BITS-1:0] grant_addr,
    input  logic [DATA_BITS-1:0] grant_wdata,
    input  logic                 owner_read_valid,
    input  logic                 owner_write_valid,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    input  logic                 mem_write_ready,
    output logic                 busy,
    output logic                 release_claim,
    output logic [IDX_BITS-1:0]  owner_idx,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    output logic                 cons_read_ready,
    output logic [DATA_BITS-1:0] cons_read_data,
    output logic                 cons_write_ready
);

    channel_state_e       state_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic                 rd_valid_q, wr_valid_q, rd_ready_q, wr_ready_q;
    logic [ADDR_BITS-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_BITS-1:0] wdata_q, rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_ready_q <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        idx_q <= grant_idx;
                        if (grant_is_write) begin
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= grant_addr;
                            wdata_q    <= grant_wdata;
                            state_q    <= StWriteWait;
                        end else begin
                            rd_valid_q <= 1'b1;
                            rd_addr_q  <= grant_addr;
                            state_q    <= StReadWait;
                        end
                    end
                end
                StReadWait: begin
                    if (mem_read_ready) begin
                        rd_valid_q <= 1'b0;
                        rd_ready_q <= 1'b1;
                        rdata_q    <= mem_read_data;
                        state_q    <= StReadRelay;
                    end
                end
                StWriteWait: begin
                    if (mem_write_ready) begin
                        wr_valid_q <= 1'b0;
                        wr_ready_q <= 1'b1;
                        state_q    <= StWriteRelay;
                    end
                end
                StReadRelay: begin
                    if (!owner_read_valid) begin
                        rd_ready_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StWriteRelay: begin
                    if (!owner_write_valid) begin
                        wr_ready_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Claim is freed on the same edge the channel returns to idle.
    assign release_claim = ((state_q == StReadRelay) && !owner_read_valid) ||
                           ((state_q == StWriteRelay) && !owner_write_valid);

    assign busy              = (state_q != StIdle);
    assign owner_idx         = idx_q;
    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wdata_q;
    assign cons_read_ready   = rd_ready_q;
    assign cons_read_data    = rdata_q;
    assign cons_write_ready  = wr_ready_q;

endmodule

// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS load/store requesters
// with round-robin grant, one transaction per channel, one channel per consumer.
// Consumer side: consumer_read_*/consumer_write_* valid/ready handshakes.
// Memory side  : mem_read_*/mem_write_* per channel.
// Optional: define MEM_CHANNEL_ARBITER_STATS_EN to add stat_grants and
// stat_stall_cycles counters (cleared on reset).
module mem_channel_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 8,
    parameter int unsigned NUM_CHANNELS  = 4
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
`ifdef MEM_CHANNEL_ARBITER_STATS_EN
    ,
    output logic [31:0]                             stat_grants,
    output logic [31:0]                             stat_stall_cycles
`endif
);

    localparam int unsigned IdxW = idx_width(NUM_CONSUMERS);

    logic [NUM_CONSUMERS-1:0]               claimed_q, claimed_d, request, granted, taken;
    logic [IdxW-1:0]                        rr_ptr_q, rr_ptr_d;
    logic [NUM_CHANNELS-1:0]                ch_busy, ch_release, ch_rready, ch_wready;
    logic [NUM_CHANNELS-1:0]                grant_valid, grant_is_write, owner_rv, owner_wv;
    logic [NUM_CHANNELS-1:0][IdxW-1:0]      grant_idx, owner_idx;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] grant_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] grant_wdata, ch_rdata;
    int                                     idx, hi;
    logic                                   found;

    assign request = consumer_read_valid | consumer_write_valid;

    // Channels pick in ascending order; 'taken' hides consumers already chosen
    // by a lower channel this cycle as well as those already claimed.
    always_comb begin
        taken          = claimed_q;
        granted        = '0;
        grant_valid    = '0;
        grant_is_write = '0;
        grant_idx      = '0;
        grant_addr     = '0;
        grant_wdata    = '0;
        idx            = 0;
        hi             = -1;
        found          = 1'b0;
        for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
            found = 1'b0;
            if (!ch_busy[ch]) begin
                for (int k = 0; k < int'(NUM_CONSUMERS); k++) begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= int'(NUM_CONSUMERS)) idx = idx - int'(NUM_CONSUMERS);
                    if (!found && request[idx] && !taken[idx]) begin
                        found               = 1'b1;
                        taken[idx]          = 1'b1;
                        granted[idx]        = 1'b1;
                        grant_valid[ch]     = 1'b1;
                        grant_idx[ch]       = IdxW'(idx);
                        grant_is_write[ch]  = !consumer_read_valid[idx];
                        grant_addr[ch]      = consumer_read_valid[idx] ?
                                              consumer_read_address[idx] :
                                              consumer_write_address[idx];
                        grant_wdata[ch]     = consumer_write_data[idx];
                        if (idx > hi) hi = idx;
                    end
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (hi >= 0) rr_ptr_d = (hi + 1 >= int'(NUM_CONSUMERS)) ? '0 : IdxW'(hi + 1);
    end

    always_comb begin
        claimed_d = claimed_q;
        for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
            if (ch_release[ch]) claimed_d[owner_idx[ch]] = 1'b0;
        end
        claimed_d = claimed_d | granted;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            claimed_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            claimed_q <= claimed_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_comb begin
        owner_rv = '0;
        owner_wv = '0;
        for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
            owner_rv[ch] = consumer_read_valid[owner_idx[ch]];
            owner_wv[ch] = consumer_write_valid[owner_idx[ch]];
        end
    end

    for (genvar g = 0; g < int'(NUM_CHANNELS); g++) begin : g_chan
        mem_arb_channel #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .IDX_BITS  (IdxW)
        ) u_chan (
            .clk               (clk),
            .reset_n           (reset_n),
            .grant_valid       (grant_valid[g]),
            .grant_idx         (grant_idx[g]),
            .grant_is_write    (grant_is_write[g]),
            .grant_addr        (grant_addr[g]),
            .grant_wdata       (grant_wdata[g]),
            .owner_read_valid  (owner_rv[g]),
            .owner_write_valid (owner_wv[g]),
            .mem_read_ready    (mem_read_ready[g]),
            .mem_read_data     (mem_read_data[g]),
            .mem_write_ready   (mem_write_ready[g]),
            .busy              (ch_busy[g]),
            .release_claim     (ch_release[g]),
            .owner_idx         (owner_idx[g]),
            .mem_read_valid    (mem_read_valid[g]),
            .mem_read_address  (mem_read_address[g]),
            .mem_write_valid   (mem_write_valid[g]),
            .mem_write_address (mem_write_address[g]),
            .mem_write_data    (mem_write_data[g]),
            .cons_read_ready   (ch_rready[g]),
            .cons_read_data    (ch_rdata[g]),
            .cons_write_ready  (ch_wready[g])
        );
    end

    // Consumer outputs come straight from channel flops; only the owner sees them.
    always_comb begin
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        for (int c = 0; c < int'(NUM_CONSUMERS); c++) begin
            for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
                if (owner_idx[ch] == IdxW'(c)) begin
                    if (ch_rready[ch]) begin
                        consumer_read_ready[c] = 1'b1;
                        consumer_read_data[c]  = ch_rdata[ch];
                    end
                    if (ch_wready[ch]) consumer_write_ready[c] = 1'b1;
                end
            end
        end
    end

`ifdef MEM_CHANNEL_ARBITER_STATS_EN
    logic [31:0] stat_grants_q, stat_stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_grants_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_grants_q <= stat_grants_q + 32'($countones(granted));
            if (|(request & ~claimed_q & ~granted)) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_grants       = stat_grants_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule
